// File: rtl/cursor_operate_pkg.sv
// Purpose: shared constants and types for the cursor/selection engine.
//   COORD_W      width of a board coordinate
//   OP_W         width of the command opcode
//   GRID_*_DEF   default board dimensions
//   OP_*         command opcodes (111 is reserved and treated as NOP)
package cursor_operate_pkg;

    localparam int unsigned COORD_W    = 4;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned GRID_W_DEF = 8;
    localparam int unsigned GRID_H_DEF = 8;

    localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
    localparam logic [OP_W-1:0] OP_UP     = 3'd1;
    localparam logic [OP_W-1:0] OP_DOWN   = 3'd2;
    localparam logic [OP_W-1:0] OP_LEFT   = 3'd3;
    localparam logic [OP_W-1:0] OP_RIGHT  = 3'd4;
    localparam logic [OP_W-1:0] OP_SELECT = 3'd5;
    localparam logic [OP_W-1:0] OP_ELIM   = 3'd6;

    // Registered cursor state as seen by the board controller.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               selected;
        logic               eliminate;
    } cursor_state_t;

endpackage

// File: rtl/cursor_operate_if.sv
// Purpose: command/result bundle between the board controller and the cursor engine.
//   x, y, selected, operation       : current cursor state and command (controller -> engine)
//   new_x, new_y, new_selected,
//   if_eliminate                    : registered results (engine -> controller)
// Modports: master = board controller side, slave = cursor engine side.
interface cursor_operate_if;
    import cursor_operate_pkg::*;

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               selected;
    logic [OP_W-1:0]    operation;
    logic [COORD_W-1:0] new_x;
    logic [COORD_W-1:0] new_y;
    logic               new_selected;
    logic               if_eliminate;

    modport master (
        output x, y, selected, operation,
        input  new_x, new_y, new_selected, if_eliminate
    );

    modport slave (
        input  x, y, selected, operation,
        output new_x, new_y, new_selected, if_eliminate
    );

endinterface

// File: rtl/cursor_operate_step.sv
// Purpose: combinational next-coordinate for one axis (module cursor_step).
//   value_i   current coordinate (may be out of range)
//   max_i     largest legal coordinate on this axis
//   inc_i     step +1 this cycle
//   dec_i     step -1 this cycle
//   wrap_i    1: wrap around at the edges, 0: clamp at the edges
//   next_c_o  resulting coordinate (combinational)
module cursor_step
    import cursor_operate_pkg::*;
(
    input  logic [COORD_W-1:0] value_i,
    input  logic [COORD_W-1:0] max_i,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               wrap_i,
    output logic [COORD_W-1:0] next_c_o
);

    logic [COORD_W-1:0] value_lim;

    // Out-of-range inputs are pulled to the last legal position before stepping.
    assign value_lim = (value_i > max_i) ? max_i : value_i;

    always_comb begin
        next_c_o = value_lim;
        if (inc_i) begin
            if (value_lim == max_i) begin
                next_c_o = wrap_i ? '0 : value_lim;
            end else begin
                next_c_o = value_lim + COORD_W'(1);
            end
        end else if (dec_i) begin
            if (value_lim == '0) begin
                next_c_o = wrap_i ? max_i : value_lim;
            end else begin
                next_c_o = value_lim - COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/cursor_operate.sv
// Purpose: cursor/selection engine; applies one command per clock to the cursor
// position and selection flag and registers the result (1-cycle latency).
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset; clears all outputs
//   cur_io  cursor_operate_if.slave: x/y/selected/operation in,
//           new_x/new_y/new_selected/if_eliminate out (all registered)
// Parameters: GRID_W, GRID_H board dimensions (each <= 16).
// Build option: define CURSOR_WRAP_EN to make moves wrap at the board edges
// instead of clamping.
module cursor_operate
    import cursor_operate_pkg::*;
#(
    parameter int unsigned GRID_W = GRID_W_DEF,
    parameter int unsigned GRID_H = GRID_H_DEF
) (
    input  logic             clk,
    input  logic             rst,
    cursor_operate_if.slave  cur_io
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

`ifdef CURSOR_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    cursor_state_t      state_q;
    cursor_state_t      state_d;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic               x_inc;
    logic               x_dec;
    logic               y_inc;
    logic               y_dec;

    // Opcode decode into per-axis step requests (UP lowers y, DOWN raises y).
    assign y_dec = (cur_io.operation == OP_UP);
    assign y_inc = (cur_io.operation == OP_DOWN);
    assign x_dec = (cur_io.operation == OP_LEFT);
    assign x_inc = (cur_io.operation == OP_RIGHT);

    cursor_step u_step_x (
        .value_i  (cur_io.x),
        .max_i    (X_MAX),
        .inc_i    (x_inc),
        .dec_i    (x_dec),
        .wrap_i   (WRAP_EN),
        .next_c_o (x_next)
    );

    cursor_step u_step_y (
        .value_i  (cur_io.y),
        .max_i    (Y_MAX),
        .inc_i    (y_inc),
        .dec_i    (y_dec),
        .wrap_i   (WRAP_EN),
        .next_c_o (y_next)
    );

    // Selection and elimination: ELIM consumes the selection and fires only if one existed.
    always_comb begin
        state_d.x         = x_next;
        state_d.y         = y_next;
        state_d.selected  = cur_io.selected;
        state_d.eliminate = 1'b0;
        case (cur_io.operation)
            OP_SELECT: state_d.selected = ~cur_io.selected;
            OP_ELIM: begin
                state_d.eliminate = cur_io.selected;
                state_d.selected  = 1'b0;
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign cur_io.new_x        = state_q.x;
    assign cur_io.new_y        = state_q.y;
    assign cur_io.new_selected = state_q.selected;
    assign cur_io.if_eliminate = state_q.eliminate;

endmodule

// File: tb/tb_cursor_operate.sv
// Purpose: directed self-checking bench for cursor_operate on an 8x8 board.
// Expected results come from a small reference model and are queued when a
// command is driven, then popped and compared one cycle later.
// Build option: CURSOR_WRAP_EN selects wrapping edges in both DUT and model.
module tb_cursor_operate;
    import cursor_operate_pkg::*;

    localparam int GW = 8;
    localparam int GH = 8;
`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        string    tag;
        logic [3:0] x;
        logic [3:0] y;
        logic       sel;
        logic       elim;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    exp_t last_exp;

    cursor_operate_if bus ();

    cursor_operate #(.GRID_W(GW), .GRID_H(GH)) dut (
        .clk    (clk),
        .rst    (rst),
        .cur_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour in plain integer arithmetic.
    function automatic exp_t model(input string tag, input int x, input int y,
                                   input bit sel, input int op);
        exp_t e;
        int nx;
        int ny;
        bit s;
        bit el;
        nx = (x > GW - 1) ? GW - 1 : x;
        ny = (y > GH - 1) ? GH - 1 : y;
        s  = sel;
        el = 1'b0;
        case (op)
            1: begin ny = ny - 1; if (ny < 0)      ny = WRAP ? GH - 1 : 0;      end
            2: begin ny = ny + 1; if (ny > GH - 1) ny = WRAP ? 0 : GH - 1;      end
            3: begin nx = nx - 1; if (nx < 0)      nx = WRAP ? GW - 1 : 0;      end
            4: begin nx = nx + 1; if (nx > GW - 1) nx = WRAP ? 0 : GW - 1;      end
            5: s = ~sel;
            6: begin el = sel; s = 1'b0; end
            default: ;
        endcase
        e.tag  = tag;
        e.x    = 4'(nx);
        e.y    = 4'(ny);
        e.sel  = s;
        e.elim = el;
        return e;
    endfunction

    task automatic chk(input string tag, input string field, input logic [3:0] obs,
                       input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, expv);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk(e.tag, "new_x", bus.new_x, e.x);
        chk(e.tag, "new_y", bus.new_y, e.y);
        chk(e.tag, "new_selected", 4'(bus.new_selected), 4'(e.sel));
        chk(e.tag, "if_eliminate", 4'(bus.if_eliminate), 4'(e.elim));
    endtask

    task automatic chk_zero(input string tag);
        exp_t z;
        z.tag  = tag;
        z.x    = 4'd0;
        z.y    = 4'd0;
        z.sel  = 1'b0;
        z.elim = 1'b0;
        chk_all(z);
    endtask

    // Drive one command, queue its expectation, compare after the next rising edge.
    task automatic step(input string tag, input int x, input int y, input bit sel,
                        input int op);
        exp_t e;
        @(negedge clk);
        bus.x         = 4'(x);
        bus.y         = 4'(y);
        bus.selected  = sel;
        bus.operation = 3'(op);
        sb_q.push_back(model(tag, x, y, sel, op));
        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard observed empty expected one entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk_all(e);
            last_exp = e;
        end
    endtask

    // Feed the previous expected result back in as the next cursor state.
    task automatic loop(input string tag, input int op);
        step(tag, int'(last_exp.x), int'(last_exp.y), last_exp.sel, op);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.x         = 4'd5;
        bus.y         = 4'd6;
        bus.selected  = 1'b1;
        bus.operation = 3'(OP_SELECT);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        // Loopback moves from (3,3), unselected.
        step("up",    3, 3, 1'b0, 1);
        loop("down",  2);
        loop("left",  3);
        loop("right", 4);

        // Edges: clamp by default, wrap when the option is built in.
        step("edge_left",  0, 3, 1'b0, 3);
        step("edge_down",  3, 7, 1'b0, 2);
        step("edge_up",    3, 0, 1'b1, 1);
        step("edge_right", 7, 3, 1'b1, 4);

        // Out-of-range inputs are limited before the command.
        step("oor_nop",  12, 15, 1'b0, 0);
        step("oor_left", 12, 3,  1'b0, 3);

        // Selection then elimination, then idle.
        step("select",   2, 5, 1'b0, 5);
        loop("elim_sel", 6);
        loop("nop_after", 0);
        step("elim_nosel", 4, 4, 1'b0, 6);
        step("reserved",   4, 6, 1'b1, 7);
        step("deselect",   1, 2, 1'b1, 5);

        // Held command repeats every cycle.
        step("hold_left0", 2, 1, 1'b0, 3);
        loop("hold_left1", 3);
        loop("hold_left2", 3);

        // Mid-run reset clears outputs without a clock edge.
        step("pre_reset", 5, 5, 1'b1, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        chk_zero("reset_over_cmd");
        @(negedge clk);
        rst = 1'b0;
        step("post_reset", 5, 5, 1'b1, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
